// File: rtl/subkey_word_generator_pkg.sv
// Shared constants, state encoding and index helpers for the Threefish-1024
// subkey word generator.
package subkey_word_generator_pkg;

    localparam int unsigned NUM_KEY_WORDS = 17;
    localparam int unsigned NUM_SUBKEYS   = 21;

    localparam logic [4:0] MAX_SUBKEY_INDEX = 5'(NUM_SUBKEYS - 1);

    localparam logic [3:0] WORD_POS_FIRST = 4'd13;
    localparam logic [3:0] WORD_POS_MID   = 4'd14;
    localparam logic [3:0] WORD_POS_LAST  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } gen_state_e;

    // Tweak index for a 5-bit subkey index (0..31).
    function automatic logic [1:0] mod3_5b(input logic [4:0] v);
        return 2'(v % 5'd3);
    endfunction

    // (v + 1) mod 3, built from mod3_5b so v = 31 does not overflow.
    function automatic logic [1:0] mod3_plus1_5b(input logic [4:0] v);
        logic [1:0] m;
        m = mod3_5b(v);
        return (m == 2'd2) ? 2'd0 : m + 2'd1;
    endfunction

endpackage

// File: rtl/subkey_word_generator_tweak_word_mux.sv
// 3:1 selection of the tweak words t0/t1/t2 by a 2-bit index.
module tweak_word_mux (
    input  logic [1:0]  sel_i,
    input  logic [63:0] t0_i,
    input  logic [63:0] t1_i,
    input  logic [63:0] t2_i,
    output logic [63:0] word_o
);

    always_comb begin
        word_o = t0_i;
        case (sel_i)
            2'd1:    word_o = t1_i;
            2'd2:    word_o = t2_i;
            default: word_o = t0_i;
        endcase
    end

endmodule

// File: rtl/subkey_word_generator.sv
// Writes tweak-adjusted subkey words 13..15 for subkey s into the selector.
// Optional SUBKEY_GEN_RANGE_CHECK_EN rejects starts with subkey index > 20.
module subkey_word_generator
    import subkey_word_generator_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [4:0]  subkey_index_i,
    input  logic [63:0] tweak0_i,
    input  logic [63:0] tweak1_i,
    input  logic [63:0] key_word_i,
    output logic [4:0]  subkey_select_o,
    output logic [3:0]  subkey_word_select_o,
    output logic        write_o,
    output logic [63:0] add64_word_o,
    output logic        busy_o,
    output logic        done_o
`ifdef SUBKEY_GEN_RANGE_CHECK_EN
    ,
    output logic        range_err_o
`endif
);

    // Handshake: start_i is a level request sampled only in IDLE; write_o and
    // done_o are single-cycle strobes with no back-pressure from the selector.

    gen_state_e  state_q, state_d;
    logic [3:0]  w_q, w_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [4:0]  s_q, s_d;
    logic [63:0] t0_q, t0_d;
    logic [63:0] t1_q, t1_d;
    logic [63:0] t2_q, t2_d;
    logic [63:0] add64_q, add64_d;
    logic        start_ok;
    logic [1:0]  tweak_sel;
    logic [63:0] tweak_word;
    logic [63:0] addend;

`ifdef SUBKEY_GEN_RANGE_CHECK_EN
    logic range_err_q, range_err_d;
    assign start_ok = start_i && (subkey_index_i <= MAX_SUBKEY_INDEX);
`else
    assign start_ok = start_i;
`endif

    tweak_word_mux u_tweak_word_mux (
        .sel_i  (tweak_sel),
        .t0_i   (t0_q),
        .t1_i   (t1_q),
        .t2_i   (t2_q),
        .word_o (tweak_word)
    );

    always_comb begin
        tweak_sel = 2'd0;
        case (w_q)
            WORD_POS_FIRST: tweak_sel = mod3_5b(s_q);
            WORD_POS_MID:   tweak_sel = mod3_plus1_5b(s_q);
            default:        tweak_sel = 2'd0;
        endcase
        addend = (w_q == WORD_POS_LAST) ? {59'b0, s_q} : tweak_word;
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        t0_d    = t0_q;
        t1_d    = t1_q;
        t2_d    = t2_q;
        add64_d = add64_q;
`ifdef SUBKEY_GEN_RANGE_CHECK_EN
        range_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    s_d     = subkey_index_i;
                    t0_d    = tweak0_i;
                    t1_d    = tweak1_i;
                    t2_d    = tweak0_i ^ tweak1_i;
                    w_d     = WORD_POS_FIRST;
                    cnt_d   = 2'd0;
                    state_d = ST_FETCH;
                end
`ifdef SUBKEY_GEN_RANGE_CHECK_EN
                range_err_d = start_i && !start_ok;
`endif
            end
            ST_FETCH: begin
                // key_word_i is valid RD_LATENCY cycles after the select moved.
                if (cnt_q == RD_LATENCY[1:0]) begin
                    add64_d = key_word_i + addend;
                    cnt_d   = 2'd0;
                    state_d = ST_WRITE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_WRITE: begin
                if (w_q < WORD_POS_LAST) begin
                    w_d     = w_q + 4'd1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            w_q     <= 4'd0;
            cnt_q   <= 2'd0;
            s_q     <= 5'd0;
            t0_q    <= 64'd0;
            t1_q    <= 64'd0;
            t2_q    <= 64'd0;
            add64_q <= 64'd0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            t0_q    <= t0_d;
            t1_q    <= t1_d;
            t2_q    <= t2_d;
            add64_q <= add64_d;
        end
    end

`ifdef SUBKEY_GEN_RANGE_CHECK_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            range_err_q <= 1'b0;
        end else begin
            range_err_q <= range_err_d;
        end
    end
    assign range_err_o = range_err_q;
`endif

    // Strobes decode straight from state so an async reset drops them at once.
    assign write_o              = (state_q == ST_WRITE);
    assign done_o               = (state_q == ST_DONE);
    assign busy_o               = (state_q == ST_FETCH) || (state_q == ST_WRITE);
    assign subkey_word_select_o = busy_o ? w_q : 4'd0;
    assign subkey_select_o      = s_q;
    assign add64_word_o         = add64_q;

endmodule

// File: tb/tb_subkey_word_generator.sv
// Directed bench for subkey_word_generator with a one-cycle-latency key store
// model; define SUBKEY_GEN_RANGE_CHECK_EN to exercise the range check.
module tb_subkey_word_generator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [4:0]  subkey_index_i = '0;
    logic [63:0] tweak0_i = '0;
    logic [63:0] tweak1_i = '0;
    logic [63:0] key_word_i = '0;
    logic [4:0]  subkey_select_o;
    logic [3:0]  subkey_word_select_o;
    logic        write_o;
    logic [63:0] add64_word_o;
    logic        busy_o;
    logic        done_o;
`ifdef SUBKEY_GEN_RANGE_CHECK_EN
    logic        range_err_o;
`endif

    logic [63:0] key_mem [17];
    logic [63:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    subkey_word_generator #(.RD_LATENCY(1)) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .start_i              (start_i),
        .subkey_index_i       (subkey_index_i),
        .tweak0_i             (tweak0_i),
        .tweak1_i             (tweak1_i),
        .key_word_i           (key_word_i),
        .subkey_select_o      (subkey_select_o),
        .subkey_word_select_o (subkey_word_select_o),
        .write_o              (write_o),
        .add64_word_o         (add64_word_o),
        .busy_o               (busy_o),
        .done_o               (done_o)
`ifdef SUBKEY_GEN_RANGE_CHECK_EN
        ,
        .range_err_o          (range_err_o)
`endif
    );

    // clock / key store model (synchronous read, one cycle latency)
    always #5 clk = ~clk;

    always @(posedge clk)
        key_word_i <= key_mem[(int'(subkey_select_o) + int'(subkey_word_select_o)) % 17];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_keys(input logic [63:0] base, input logic [63:0] step);
        for (int i = 0; i < 17; i++) key_mem[i] = base + step * 64'(i);
    endtask

    task automatic pop_check(input string tag);
        if (exp_q.size() == 0) check_eq({tag, "_unexpected"}, 64'd1, 64'd0);
        else check_eq(tag, add64_word_o, exp_q.pop_front());
    endtask

    // One generation; start sampled at edge 0, cycle k is the period ending at edge k.
    task automatic run_gen(input logic [4:0] s, input logic [63:0] t0, input logic [63:0] t1,
                           input logic [63:0] e13, input logic [63:0] e14, input logic [63:0] e15,
                           input bit hold_start);
        int  n_wr;
        bit  done_seen;
        exp_q.push_back(e13);
        exp_q.push_back(e14);
        exp_q.push_back(e15);
        @(negedge clk);
        subkey_index_i = s;
        tweak0_i = t0;
        tweak1_i = t1;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start_i = 1'b0;
        n_wr = 0;
        done_seen = 1'b0;
        for (int cyc = 1; cyc <= 30 && !done_seen; cyc++) begin
            @(negedge clk);
            check_eq("busy", 64'(busy_o), 64'(cyc <= 9));
            if (write_o) begin
                check_eq("wr_cycle", 64'(cyc), 64'(3 * (n_wr + 1)));
                check_eq("wr_sel", 64'(subkey_word_select_o), 64'(13 + n_wr));
                pop_check("wr_data");
                n_wr++;
            end
            if (done_o) begin
                check_eq("done_cycle", 64'(cyc), 64'd10);
                check_eq("done_writes", 64'(n_wr), 64'd3);
                check_eq("done_sel", 64'(subkey_word_select_o), 64'd0);
                done_seen = 1'b1;
            end
        end
        if (!done_seen) check_eq("done_timeout", 64'd0, 64'd1);
        @(negedge clk);
        check_eq("idle_busy", 64'(busy_o), 64'd0);
        check_eq("hold_data", add64_word_o, e15);
        check_eq("hold_s", 64'(subkey_select_o), 64'(s));
    endtask

    initial begin
        int n_wr;
        set_keys(64'd0, 64'd0);

        // reset state and idle
        @(negedge clk);
        check_eq("rst_write", 64'(write_o), 64'd0);
        check_eq("rst_done", 64'(done_o), 64'd0);
        check_eq("rst_busy", 64'(busy_o), 64'd0);
        check_eq("rst_sel", 64'(subkey_select_o), 64'd0);
        check_eq("rst_wsel", 64'(subkey_word_select_o), 64'd0);
        check_eq("rst_data", add64_word_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        n_wr = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (write_o || busy_o || done_o) n_wr++;
        end
        check_eq("idle_quiet", 64'(n_wr), 64'd0);

        // basic, tweak rotation, carry wrap, wrap-around indices
        set_keys(64'h1000, 64'd0);
        run_gen(5'd0, 64'h10, 64'h20, 64'h1010, 64'h1020, 64'h1000, 1'b0);
        set_keys(64'd0, 64'd0);
        run_gen(5'd5, 64'h1, 64'h3, 64'h2, 64'h1, 64'h5, 1'b0);
        set_keys(64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        run_gen(5'd1, 64'h3, 64'h5, 64'h4, 64'h5, 64'h0, 1'b0);
        set_keys(64'd0, 64'h100);
        run_gen(5'd16, 64'h1, 64'h2, 64'hC02, 64'hD03, 64'hE10, 1'b0);
        run_gen(5'd20, 64'h10, 64'h30, 64'h1020, 64'h10, 64'h114, 1'b0);
`ifndef SUBKEY_GEN_RANGE_CHECK_EN
        run_gen(5'd31, 64'h1, 64'h2, 64'hA02, 64'hB03, 64'hC1F, 1'b0);
`endif

        // start held high: one generation, then re-accepted after done
        set_keys(64'd0, 64'd0);
        run_gen(5'd2, 64'h7, 64'h9, 64'hE, 64'h7, 64'h2, 1'b1);
        exp_q.push_back(64'hE);
        exp_q.push_back(64'h7);
        n_wr = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                check_eq("restart_busy", 64'(busy_o), 64'd1);
                check_eq("restart_wsel", 64'(subkey_word_select_o), 64'd13);
            end
            if (write_o) begin
                pop_check("restart_data");
                n_wr++;
                if (n_wr == 2) begin
                    // async reset during the second WRITE
                    rst = 1'b1;
                    start_i = 1'b0;
                    #1;
                    check_eq("arst_write", 64'(write_o), 64'd0);
                    check_eq("arst_busy", 64'(busy_o), 64'd0);
                    check_eq("arst_wsel", 64'(subkey_word_select_o), 64'd0);
                    check_eq("arst_data", add64_word_o, 64'd0);
                    break;
                end
            end
        end
        check_eq("restart_writes", 64'(n_wr), 64'd2);
        start_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_keys(64'h1000, 64'd0);
        run_gen(5'd0, 64'h10, 64'h20, 64'h1010, 64'h1020, 64'h1000, 1'b0);

`ifdef SUBKEY_GEN_RANGE_CHECK_EN
        @(negedge clk);
        subkey_index_i = 5'd21;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(negedge clk);
        check_eq("rerr_pulse", 64'(range_err_o), 64'd1);
        check_eq("rerr_busy", 64'(busy_o), 64'd0);
        n_wr = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (write_o || busy_o || range_err_o) n_wr++;
        end
        check_eq("rerr_quiet", 64'(n_wr), 64'd0);
`endif

        check_eq("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
